// File: rtl/if_id_pipe_hs.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_pipe_hs
//  Purpose  : IF->ID pipeline register with valid/ready handshake, flush
//             bubbles and a saturating stall counter. Defining IF_ID_SKID_EN
//             adds a 2-entry skid buffer so in_ready depends on state only.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_pipe_hs #(
    parameter int                PC_W        = 32,
    parameter int                INST_W      = 32,
    parameter logic [INST_W-1:0] BUBBLE_INST = '0,
    parameter logic [PC_W-1:0]   RST_PC      = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_main_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [INST_W-1:0] r_main_inst;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_accept;
    logic              w_consume;

    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_valid & out_ready;

`ifdef IF_ID_SKID_EN
    logic              r_skid_valid;
    logic [PC_W-1:0]   r_skid_pc;
    logic [INST_W-1:0] r_skid_inst;

    // Registered-only ready: decode back-pressure never reaches fetch combinationally.
    assign in_ready = ~r_skid_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= RST_PC;
            r_main_inst  <= BUBBLE_INST;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= BUBBLE_INST;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_inst  <= BUBBLE_INST;
            r_skid_valid <= 1'b0;
        end else if (w_consume && r_skid_valid) begin
            r_main_valid <= 1'b1;
            r_main_pc    <= r_skid_pc;
            r_main_inst  <= r_skid_inst;
            r_skid_valid <= w_accept;
            if (w_accept) begin
                r_skid_pc   <= in_pc;
                r_skid_inst <= in_inst;
            end
        end else if (w_consume || !r_main_valid) begin
            r_main_valid <= w_accept;
            if (w_accept) begin
                r_main_pc   <= in_pc;
                r_main_inst <= in_inst;
            end else begin
                r_main_inst <= BUBBLE_INST;
            end
        end else if (w_accept) begin
            // Main is held by back-pressure: park the new entry behind it.
            r_skid_valid <= 1'b1;
            r_skid_pc    <= in_pc;
            r_skid_inst  <= in_inst;
        end
    end
`else
    assign in_ready = (~r_main_valid | out_ready) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= RST_PC;
            r_main_inst  <= BUBBLE_INST;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_inst  <= BUBBLE_INST;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main_pc    <= in_pc;
            r_main_inst  <= in_inst;
        end else if (w_consume) begin
            r_main_valid <= 1'b0;
            r_main_inst  <= BUBBLE_INST;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && !flush && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid    = r_main_valid;
    assign out_pc       = r_main_pc;
    assign out_inst     = r_main_inst;
    assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_pipe_hs
//  Purpose  : Directed and randomized checks of if_id_pipe_hs against a
//             FIFO-queue reference model; works with IF_ID_SKID_EN on or off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe_hs;

    localparam int          PC_W   = 32;
    localparam int          INST_W = 32;
    localparam logic [31:0] BUBBLE = 32'h0000_0013;
    localparam logic [31:0] RSTPC  = 32'h0000_1000;
    localparam int          CNT_W  = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;
`ifdef IF_ID_SKID_EN
    localparam int          CAP    = 2;
`else
    localparam int          CAP    = 1;
`endif

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc = '0;
    logic [INST_W-1:0] in_inst = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [CNT_W-1:0]  stall_cycles;

    int checks = 0;
    int errors = 0;

    if_id_pipe_hs #(
        .PC_W(PC_W), .INST_W(INST_W), .BUBBLE_INST(BUBBLE),
        .RST_PC(RSTPC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of capacity CAP.
    entry_t          q[$];
    logic [PC_W-1:0] m_hold = RSTPC;
    int              m_cnt  = 0;

    function automatic logic m_in_ready();
        if (flush) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic [PC_W-1:0] m_pc();
        return (q.size() > 0) ? q[0].pc : m_hold;
    endfunction

    function automatic logic [INST_W-1:0] m_inst();
        return (q.size() > 0) ? q[0].inst : BUBBLE;
    endfunction

    always @(posedge clk) begin
        logic acc;
        entry_t e;
        if (rst) begin
            q.delete();
            m_hold = RSTPC;
            m_cnt  = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && m_in_ready();
            if (q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.pc   = in_pc;
                e.inst = in_inst;
                q.push_back(e);
            end
            if (q.size() > 0) m_hold = q[0].pc;
        end
    end

    property p_stall_stable;
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> ($stable(out_pc) && $stable(out_inst));
    endproperty
    a_stall_stable: assert property (p_stall_stable)
        else $error("FAIL stall_stable out_pc=%h out_inst=%h changed while stalled", out_pc, out_inst);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== RSTPC || out_inst !== BUBBLE ||
            stall_cycles !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got v=%b pc=%h inst=%h stall=%0d rdy=%b, want v=0 pc=%h inst=%h stall=0 rdy=1",
                     out_valid, out_pc, out_inst, stall_cycles, in_ready, RSTPC, BUBBLE);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs[3];
        logic [31:0] insts[3];
        pcs   = '{32'h100, 32'h104, 32'h108};
        insts = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            drive(1, pcs[i], insts[i], 1, 0, 0);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== insts[i]) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, pcs[i], insts[i]);
            end
        end
        drive(0, 0, 0, 1, 0, 0);
        step();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h108 || out_inst !== BUBBLE || stall_cycles !== '0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b pc=%h inst=%h stall=%0d, want v=0 pc=00000108 inst=%h stall=0",
                     out_valid, out_pc, out_inst, stall_cycles, BUBBLE);
        end
    endtask

    task automatic test_backpressure();
        logic acc;
        logic v;
        drive(1, 32'h100, 32'hA, 0, 0, 0);
        step();
        v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(v, 32'h104, 32'hB, 0, 0, 0);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 || in_ready !== m_in_ready()) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h rdy=%b, want v=1 pc=00000100 rdy=%b",
                         k, out_valid, out_pc, in_ready, m_in_ready());
            end
            acc = v && in_ready;
            step();
            if (acc) v = 1'b0;
        end
        in_valid = v;
        #1;
        checks++;
        if (stall_cycles !== 4'd3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got stall=%0d rdy=%b, want stall=3 rdy=0", stall_cycles, in_ready);
        end
        for (int k = 0; k < 2; k++) begin
            drive(v, 32'h104, 32'hB, 1, 0, 0);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== (k == 0 ? 32'h100 : 32'h104)) begin
                errors++;
                $display("FAIL bp_release[%0d]: got v=%b pc=%h, want v=1 pc=%h",
                         k, out_valid, out_pc, (k == 0 ? 32'h100 : 32'h104));
            end
            acc = v && in_ready;
            step();
            if (acc) v = 1'b0;
        end
        drive(0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h104 || out_inst !== BUBBLE) begin
            errors++;
            $display("FAIL bp_drain: got v=%b pc=%h inst=%h, want v=0 pc=00000104 inst=%h",
                     out_valid, out_pc, out_inst, BUBBLE);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h200, 32'h20, 0, 0, 0);
        step();
        drive(1, 32'h204, 32'h21, 0, 0, 0);
        step();
        drive(1, 32'h208, 32'h22, 1, 1, 0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got rdy=%b, want rdy=0", in_ready);
        end
        step();
        drive(0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== BUBBLE || out_pc !== 32'h200) begin
            errors++;
            $display("FAIL flush_state: got v=%b pc=%h inst=%h, want v=0 pc=00000200 inst=%h",
                     out_valid, out_pc, out_inst, BUBBLE);
        end
        drive(1, 32'h20C, 32'h23, 1, 0, 0);
        step();
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20C || out_inst !== 32'h23) begin
            errors++;
            $display("FAIL flush_resume: got v=%b pc=%h inst=%h, want v=1 pc=0000020c inst=00000023",
                     out_valid, out_pc, out_inst);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        drive(1, 32'h300, 32'h30, 0, 0, 0);
        step();
        drive(1, 32'h304, 32'h31, 0, 0, 0);
        step();
        drive(1, 32'h308, 32'h32, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== RSTPC || out_inst !== BUBBLE ||
            stall_cycles !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%b pc=%h inst=%h stall=%0d rdy=%b, want v=0 pc=%h inst=%h stall=0 rdy=1",
                     out_valid, out_pc, out_inst, stall_cycles, in_ready, RSTPC, BUBBLE);
        end
    endtask

    task automatic test_saturation();
        int exp;
        drive(1, 32'h400, 32'h40, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = (k > CMAX) ? CMAX : k;
            checks++;
            if (stall_cycles !== CNT_W'(exp) || out_pc !== 32'h400) begin
                errors++;
                $display("FAIL sat[%0d]: got stall=%0d pc=%h, want stall=%0d pc=00000400",
                         k, stall_cycles, out_pc, exp);
            end
        end
        drive(0, 0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (stall_cycles !== 4'd15) begin
            errors++;
            $display("FAIL sat_flush_keep: got stall=%0d, want stall=15", stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [31:0] next_pc;
        logic        acc;
        next_pc = 32'h8000;
        drive(0, 0, 0, 0, 0, 1);
        step();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(99) < 70, next_pc, $urandom, $urandom_range(99) < 60,
                  $urandom_range(99) < 5, $urandom_range(99) < 2);
            #1;
            checks++;
            if (out_valid !== m_valid() || out_pc !== m_pc() || out_inst !== m_inst() ||
                stall_cycles !== CNT_W'(m_cnt) || in_ready !== m_in_ready()) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b pc=%h inst=%h stall=%0d rdy=%b, want v=%b pc=%h inst=%h stall=%0d rdy=%b",
                         c, out_valid, out_pc, out_inst, stall_cycles, in_ready,
                         m_valid(), m_pc(), m_inst(), m_cnt, m_in_ready());
            end
            acc = in_valid && m_in_ready() && !rst;
            step();
            if (acc) next_pc = next_pc + 32'd4;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
